// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size encodings and LSU state type.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu.sv
// Load/store unit: turns one core memory access into a single data-memory
// request, stalling the core until the access completes or is rejected.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, wd_q, rd_q;
    logic        we_q, misalign_q;
    logic [2:0]  size_q;
    logic        access_bad;
    logic [3:0]  be;
    logic [31:0] wd_rep, load_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (core_size_i)
            LDST_B, LDST_BU: access_bad = 1'b0;
            LDST_H, LDST_HU: access_bad = core_addr_i[0];
            LDST_W:          access_bad = |core_addr_i[1:0];
            default:         access_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (core_req_i) state_d = access_bad ? DONE : REQ;
            REQ:     if (mem_ready_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The memory bus is zero outside REQ, so a reset mid-request drops it at once.
    always_comb begin
        mem_req_o    = (state_q == REQ);
        mem_we_o     = mem_req_o & we_q;
        mem_be_o     = mem_req_o ? be : 4'b0000;
        mem_addr_o   = mem_req_o ? addr_q : 32'd0;
        mem_wd_o     = mem_req_o ? wd_rep : 32'd0;
        core_stall_o = core_req_i && (state_q != DONE);
        misalign_o   = misalign_q && (state_q == DONE);
        core_rd_o    = rd_q;
    end

    always_comb begin
        rd_byte = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
        rd_half = mem_rd_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            LDST_B, LDST_BU: begin
                be       = 4'b0001 << addr_q[1:0];
                wd_rep   = {4{wd_q[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be       = 4'b0011 << {addr_q[1], 1'b0};
                wd_rep   = {2{wd_q[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wd_rep   = wd_q;
            end
        endcase
        case (size_q)
            LDST_B:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            LDST_BU: load_ext = {24'd0, rd_byte};
            LDST_H:  load_ext = {{16{rd_half[15]}}, rd_half};
            LDST_HU: load_ext = {16'd0, rd_half};
            default: load_ext = mem_rd_i;
        endcase
    end

    // Request capture in IDLE; the result register only changes when an access finishes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= 32'd0;
            wd_q       <= 32'd0;
            we_q       <= 1'b0;
            size_q     <= 3'd0;
            misalign_q <= 1'b0;
            rd_q       <= 32'd0;
        end else if (state_q == IDLE && core_req_i) begin
            addr_q     <= core_addr_i;
            wd_q       <= core_wd_i;
            we_q       <= core_we_i;
            size_q     <= core_size_i;
            misalign_q <= access_bad;
            if (access_bad) rd_q <= 32'd0;
        end else if (state_q == REQ && mem_ready_i) begin
            rd_q <= we_q ? 32'd0 : load_ext;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: a driver pushes expected bus/result records,
// a memory responder and two monitors check them as the DUT presents them.
module tb_riscv_lsu;
    import riscv_pkg::*;

    logic        clk_i, rst_ni;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic        core_stall_o, misalign_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        mem_ready_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          waits;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int resp_cnt = 0;
    logic [31:0] last_rd = 32'd0;

    riscv_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .misalign_o(misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte lanes, replicated store data and extended load value.
    function automatic void model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  output logic bad, output logic [3:0] be,
                                  output logic [31:0] mwd, output logic [31:0] rd);
        int nbytes, ofs;
        logic [31:0] mask, val;
        case (size)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        ofs = int'(addr[1:0]);
        bad = (nbytes == 0) || ((ofs % nbytes) != 0);
        be = 4'b0000;
        mwd = wd;
        rd = 32'd0;
        if (!bad) begin
            for (int k = 0; k < 4; k++) begin
                be[k] = (k >= ofs) && (k < ofs + nbytes);
                mwd[8*k +: 8] = wd[8*(k % nbytes) +: 8];
            end
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            val = (rdata >> (8 * ofs)) & mask;
            if ((size == 3'd0 || size == 3'd1) && val[8*nbytes-1]) val = val | ~mask;
            if (!we) rd = val;
        end
    endfunction

    task automatic doReset();
        rst_ni = 1'b0;
        core_req_i = 1'b0;
        mem_q.delete();
        rsp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdata,
                                 input int waits, input bit hold);
        logic bad;
        logic [3:0] be;
        logic [31:0] mwd, rd;
        int cycles = 0;
        bit released = 0;
        model(we, size, addr, wd, rdata, bad, be, mwd, rd);
        if (!bad) mem_q.push_back('{we: we, be: be, addr: addr, wd: mwd, rdata: rdata, waits: waits});
        rsp_q.push_back('{rd: rd, mis: bad});
        @(posedge clk_i);
        #1;
        core_req_i = 1'b1;
        core_we_i = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i = wd;
        while (cycles < 40 && !released) begin
            @(negedge clk_i);
            cycles++;
            if (!core_stall_o) released = 1;
        end
        checkOutput("release_latency", released ? cycles : 32'hFFFF_FFFF, bad ? 2 : waits + 3);
        if (!released) doReset();
        if (!hold) begin
            @(posedge clk_i);
            #1;
            core_req_i = 1'b0;
            core_we_i = 1'($urandom);
            core_size_i = 3'($urandom);
            core_addr_i = $urandom;
            core_wd_i = $urandom;
        end
    endtask

    // Memory responder: answers the oldest expected request after its wait count.
    initial begin
        mem_ready_i = 1'b0;
        mem_rd_i = 32'd0;
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni) begin
                resp_cnt = 0;
                mem_ready_i = 1'b0;
            end else if (mem_req_o && mem_q.size() > 0) begin
                if (resp_cnt == mem_q[0].waits) begin
                    mem_ready_i = 1'b1;
                    mem_rd_i = mem_q[0].rdata;
                    void'(mem_q.pop_front());
                    resp_cnt = 0;
                end else begin
                    mem_ready_i = 1'b0;
                    mem_rd_i = $urandom;
                    resp_cnt++;
                end
            end else begin
                mem_ready_i = 1'($urandom);
                mem_rd_i = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && mem_req_o) begin
                checkOutput("req_expected", 32'(mem_q.size() > 0), 32'd1);
                if (mem_q.size() > 0) begin
                    checkOutput("mem_we", 32'(mem_we_o), 32'(mem_q[0].we));
                    checkOutput("mem_be", 32'(mem_be_o), 32'(mem_q[0].be));
                    checkOutput("mem_addr", mem_addr_o, mem_q[0].addr);
                    checkOutput("mem_wd", mem_wd_o, mem_q[0].wd);
                end
            end
        end
    end

    initial begin
        forever begin
            rsp_exp_t r;
            @(negedge clk_i);
            if (!rst_ni) begin
                last_rd = 32'd0;
            end else if (core_req_i && !core_stall_o) begin
                checkOutput("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    checkOutput("core_rd", core_rd_o, r.rd);
                    checkOutput("misalign_done", 32'(misalign_o), 32'(r.mis));
                    last_rd = r.rd;
                end
            end else begin
                checkOutput("misalign_quiet", 32'(misalign_o), 32'd0);
                if (!core_req_i) checkOutput("core_rd_hold", core_rd_o, last_rd);
            end
        end
    end

    initial begin
        #2000000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic [2:0]  sz;
        logic [31:0] ad;
        rst_ni = 1'b0;
        core_req_i = 1'b0;
        core_we_i = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'd0;
        core_wd_i = 32'd0;
        #1;
        checkOutput("reset_mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("reset_mem_bus", {mem_be_o, 27'd0, mem_we_o} | mem_addr_o | mem_wd_o, 32'd0);
        checkOutput("reset_core_rd", core_rd_o, 32'd0);
        checkOutput("reset_misalign", 32'(misalign_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        applyStimulus(1'b1, LDST_W,  32'h100, 32'hDEADBEEF, 32'h0, 2, 0);
        applyStimulus(1'b0, LDST_B,  32'h103, 32'h0, 32'h80123456, 0, 0);
        applyStimulus(1'b0, LDST_BU, 32'h103, 32'h0, 32'h80123456, 1, 0);
        applyStimulus(1'b1, LDST_H,  32'h102, 32'h1234ABCD, 32'h0, 0, 0);
        applyStimulus(1'b0, LDST_W,  32'h101, 32'h0, 32'hFFFFFFFF, 0, 0);
        applyStimulus(1'b0, 3'd3,    32'h200, 32'h0, 32'h12345678, 0, 0);
        applyStimulus(1'b0, LDST_H,  32'h202, 32'h0, 32'h80015555, 1, 1);
        applyStimulus(1'b0, LDST_W,  32'h204, 32'h0, 32'hCAFEF00D, 0, 0);

        // Reset while a request is outstanding must drop the bus and forget it.
        core_req_i = 1'b1;
        core_we_i = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h300;
        mem_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h300, wd: core_wd_i, rdata: 32'h0, waits: 30});
        rsp_q.push_back('{rd: 32'h0, mis: 1'b0});
        repeat (3) @(negedge clk_i);
        checkOutput("req_before_reset", 32'(mem_req_o), 32'd1);
        #2 rst_ni = 1'b0;
        core_req_i = 1'b0;
        #1;
        checkOutput("req_dropped_async", 32'(mem_req_o), 32'd0);
        checkOutput("bus_cleared_async", {mem_be_o, 27'd0, mem_we_o} | mem_addr_o | mem_wd_o, 32'd0);
        mem_q.delete();
        rsp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("idle_after_reset", {31'd0, mem_req_o}, 32'd0);
        end

        for (int i = 0; i < 200; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            ad = $urandom;
            if ($urandom_range(0, 2) != 0) ad[1:0] = (sz == LDST_H || sz == LDST_HU) ? {ad[1], 1'b0} : 2'b00;
            applyStimulus(1'($urandom), sz, ad, $urandom, $urandom,
                          $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end
        @(posedge clk_i);
        #1 core_req_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("scoreboard_drained", mem_q.size() + rsp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
